// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: issues fetch requests ahead of decode, buffers in-order
// responses in a DEPTH-entry FIFO and squashes stale work on redirect. Optional macro: IFQ_BYPASS_EN.
module instruction_prefetch_queue #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 4,
    parameter int PC_INC   = 4,
    parameter int RESET_PC = 0
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_n,
    input  logic                     i_Enable,
    input  logic                     i_Redirect,
    input  logic [ADDR_W-1:0]        i_RedirectPc,
    output logic                     o_MemReq,
    output logic [ADDR_W-1:0]        o_MemAddr,
    input  logic                     i_MemGnt,
    input  logic                     i_MemValid,
    input  logic [DATA_W-1:0]        i_MemData,
    output logic                     o_InstValid,
    output logic [DATA_W-1:0]        o_Instruction,
    output logic [ADDR_W-1:0]        o_ProgramCounter,
    input  logic                     i_InstReady,
    output logic [$clog2(DEPTH):0]   o_Level,
    output logic [1:0]               o_DbgState
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

    // Memory side: o_MemReq/o_MemAddr hold a request, a transfer happens on any cycle with
    // o_MemReq & i_MemGnt. Decode side: a transfer happens on any cycle with o_InstValid & i_InstReady.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t              r_State;
    state_t              w_StateNext;
    logic [ADDR_W-1:0]   r_FetchPc;
    logic [ADDR_W-1:0]   r_RespPc;
    logic [CNT_W-1:0]    r_Outstanding;
    logic [CNT_W-1:0]    r_Drop;
    logic [CNT_W-1:0]    r_Count;
    logic [PTR_W-1:0]    r_WrPtr;
    logic [PTR_W-1:0]    r_RdPtr;
    logic                r_MemReq;
    logic [DATA_W-1:0]   r_FifoData [DEPTH];
    logic [ADDR_W-1:0]   r_FifoPc   [DEPTH];

    logic                w_Grant;
    logic                w_Resp;
    logic                w_RespKeep;
    logic                w_HeadValid;
    logic                w_Push;
    logic                w_Pop;
    logic                w_ReqNext;
    logic [CNT_W-1:0]    w_OutNext;
    logic [CNT_W-1:0]    w_DropNext;
    logic [CNT_W-1:0]    w_CountNext;

    assign w_Grant     = r_MemReq & i_MemGnt;
    // A response is only meaningful while something is in flight.
    assign w_Resp      = i_MemValid & (r_Outstanding != '0);
    assign w_RespKeep  = w_Resp & (r_Drop == '0) & ~i_Redirect;
    assign w_HeadValid = (r_Count != '0);
    assign w_Pop       = w_HeadValid & i_InstReady;

`ifdef IFQ_BYPASS_EN
    logic w_Bypass;
    assign w_Bypass         = w_RespKeep & ~w_HeadValid;
    assign w_Push           = w_RespKeep & ~(w_Bypass & i_InstReady);
    assign o_InstValid      = w_HeadValid | w_Bypass;
    assign o_Instruction    = w_HeadValid ? r_FifoData[r_RdPtr] : (w_Bypass ? i_MemData : '0);
    assign o_ProgramCounter = w_HeadValid ? r_FifoPc[r_RdPtr]   : (w_Bypass ? r_RespPc  : '0);
`else
    assign w_Push           = w_RespKeep;
    assign o_InstValid      = w_HeadValid;
    assign o_Instruction    = w_HeadValid ? r_FifoData[r_RdPtr] : '0;
    assign o_ProgramCounter = w_HeadValid ? r_FifoPc[r_RdPtr]   : '0;
`endif

    always_comb begin
        w_OutNext = r_Outstanding;
        if (w_Grant && !w_Resp)
            w_OutNext = r_Outstanding + CNT_W'(1);
        else if (!w_Grant && w_Resp)
            w_OutNext = r_Outstanding - CNT_W'(1);
    end

    always_comb begin
        w_CountNext = r_Count;
        if (i_Redirect)
            w_CountNext = '0;
        else if (w_Push && !w_Pop)
            w_CountNext = r_Count + CNT_W'(1);
        else if (!w_Push && w_Pop)
            w_CountNext = r_Count - CNT_W'(1);
    end

    // On redirect every request still in flight afterwards belongs to the old stream.
    always_comb begin
        w_DropNext = r_Drop;
        if (i_Redirect)
            w_DropNext = w_OutNext;
        else if (w_Resp && (r_Drop != '0))
            w_DropNext = r_Drop - CNT_W'(1);
    end

    always_comb begin
        w_StateNext = r_State;
        unique case (r_State)
            IDLE:    if (i_Enable) w_StateNext = RUN;
            RUN:     if (!i_Enable) w_StateNext = DRAIN;
            DRAIN: begin
                if (i_Enable)
                    w_StateNext = RUN;
                else if (r_Outstanding == '0)
                    w_StateNext = IDLE;
            end
            default: w_StateNext = IDLE;
        endcase
    end

    // Registered request: reserve a queue slot for every request in flight.
    assign w_ReqNext = (w_StateNext == RUN) &&
                       (({1'b0, w_CountNext} + {1'b0, w_OutNext}) < (CNT_W + 1)'(DEPTH));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State       <= IDLE;
            r_MemReq      <= 1'b0;
            r_FetchPc     <= PC0;
            r_RespPc      <= PC0;
            r_Outstanding <= '0;
            r_Drop        <= '0;
            r_Count       <= '0;
            r_WrPtr       <= '0;
            r_RdPtr       <= '0;
        end else begin
            r_State       <= w_StateNext;
            r_MemReq      <= w_ReqNext;
            r_Outstanding <= w_OutNext;
            r_Drop        <= w_DropNext;
            r_Count       <= w_CountNext;
            if (i_Redirect) begin
                r_FetchPc <= i_RedirectPc;
                r_RespPc  <= i_RedirectPc;
                r_WrPtr   <= '0;
                r_RdPtr   <= '0;
            end else begin
                if (w_Grant)    r_FetchPc <= r_FetchPc + INC;
                if (w_RespKeep) r_RespPc  <= r_RespPc + INC;
                if (w_Push)     r_WrPtr   <= r_WrPtr + PTR_W'(1);
                if (w_Pop)      r_RdPtr   <= r_RdPtr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_Push) begin
            r_FifoData[r_WrPtr] <= i_MemData;
            r_FifoPc[r_WrPtr]   <= r_RespPc;
        end
    end

    assign o_MemReq   = r_MemReq;
    assign o_MemAddr  = r_FetchPc;
    assign o_Level    = r_Count;
    assign o_DbgState = r_State;

endmodule
